id_bypass_stage: RTL and testbench

ID_BYPASS_STAGE -- requirements
Module: id_bypass_stage

---
 rtl/id_bypass_stage.sv | 151 +++++++++++++++
 tb/tb_id_bypass_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_bypass_stage.sv
// id_bypass_stage -- decode/issue pipeline stage with operand bypass.
//
// Holds one payload (valid, bus, two source addresses, two read-use flags)
// and resolves both source operands against NSRC forwarding producers
// (index 0 = youngest) or the register file. A source whose newest in-flight
// producer cannot yet supply its result is a hazard and blocks the stage.
//
// Optional feature macro: ID_BYPASS_FWD_EN
//   defined   -> results are taken from the lowest-index matching producer
//                when it is ready; a not-ready match stalls.
//   undefined -> no bypass: any match on a used source stalls until the
//                producer retires; operands always come from rf_rdata.
//
// Handshake: a transfer happens on a rising edge when the sender's valid and
// the receiver's allowin are both high; valid may not depend on allowin.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   in_valid/in_allowin/in_bus  upstream payload handshake
//   in_raddr, in_ruse           source addresses {src1,src0} and read flags
//   flush                       drop the held payload
//   rf_raddr, rf_rdata          register-file read port (held sources)
//   fwd_valid/ready/dest/data   forwarding producers
//   out_valid/out_allowin       downstream handshake
//   out_bus, out_src            held payload and resolved operands {src1,src0}
//   stall_cnt                   saturating count of hazard-stalled cycles
module id_bypass_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NSRC   = 3,
  parameter int BUS_W  = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_allowin,
  input  logic [BUS_W-1:0]       in_bus,
  input  logic [2*REG_AW-1:0]    in_raddr,
  input  logic [1:0]             in_ruse,
  input  logic                   flush,
  output logic [2*REG_AW-1:0]    rf_raddr,
  input  logic [2*DATA_W-1:0]    rf_rdata,
  input  logic [NSRC-1:0]        fwd_valid,
  input  logic [NSRC-1:0]        fwd_ready,
  input  logic [NSRC*REG_AW-1:0] fwd_dest,
  input  logic [NSRC*DATA_W-1:0] fwd_data,
  output logic                   out_valid,
  input  logic                   out_allowin,
  output logic [BUS_W-1:0]       out_bus,
  output logic [2*DATA_W-1:0]    out_src,
  output logic [31:0]            stall_cnt
);

  logic                   valid_q;
  logic [BUS_W-1:0]       bus_q;
  logic [2*REG_AW-1:0]    raddr_q;
  logic [1:0]             ruse_q;
  logic [31:0]            stall_q;

  logic [1:0]             hazard;
  logic [2*DATA_W-1:0]    src_d;
  logic                   ready_go;
  logic                   capture;

  // Operand resolution. The producer scan runs youngest-first so the first
  // hit is the most recent writer of the register.
  always_comb begin : resolve
    logic [REG_AW-1:0] addr;
    logic              found;
`ifdef ID_BYPASS_FWD_EN
    logic              sel_ready;
    logic [DATA_W-1:0] sel_data;
`endif
    hazard = '0;
    src_d  = '0;
    for (int s = 0; s < 2; s++) begin
      addr  = raddr_q[s*REG_AW +: REG_AW];
      found = 1'b0;
`ifdef ID_BYPASS_FWD_EN
      sel_ready = 1'b0;
      sel_data  = '0;
`endif
      for (int i = 0; i < NSRC; i++) begin
        if (!found && ruse_q[s] && (addr != '0) && fwd_valid[i] &&
            (fwd_dest[i*REG_AW +: REG_AW] == addr)) begin
          found = 1'b1;
`ifdef ID_BYPASS_FWD_EN
          sel_ready = fwd_ready[i];
          sel_data  = fwd_data[i*DATA_W +: DATA_W];
`endif
        end
      end
`ifdef ID_BYPASS_FWD_EN
      hazard[s] = found & ~sel_ready;
      if (addr == '0)
        src_d[s*DATA_W +: DATA_W] = '0;
      else if (found)
        src_d[s*DATA_W +: DATA_W] = sel_data;
      else
        src_d[s*DATA_W +: DATA_W] = rf_rdata[s*DATA_W +: DATA_W];
`else
      hazard[s] = found;
      src_d[s*DATA_W +: DATA_W] = (addr == '0) ? '0 : rf_rdata[s*DATA_W +: DATA_W];
`endif
    end
  end

`ifndef ID_BYPASS_FWD_EN
  // Without bypass the producers' readiness and results are not consumed.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_ready, fwd_data};
`endif

  assign ready_go   = ~|hazard;
  assign in_allowin = ~valid_q | (ready_go & out_allowin);
  assign capture    = in_valid & in_allowin & ~flush;

  assign out_valid  = valid_q & ready_go;
  // Gated to zero when empty so nothing stale is visible downstream.
  assign out_bus    = valid_q ? bus_q : '0;
  assign out_src    = valid_q ? src_d : '0;
  assign rf_raddr   = raddr_q;
  assign stall_cnt  = stall_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      bus_q   <= '0;
      raddr_q <= '0;
      ruse_q  <= '0;
      stall_q <= '0;
    end else begin
      // flush wins over any simultaneous capture
      if (flush)
        valid_q <= 1'b0;
      else if (in_allowin)
        valid_q <= in_valid;

      if (capture) begin
        bus_q   <= in_bus;
        raddr_q <= in_raddr;
        ruse_q  <= in_ruse;
      end

      // Only hazard stalls count; back-pressure and flush cycles do not.
      if (valid_q && !ready_go && !flush && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_id_bypass_stage.sv
module tb_id_bypass_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 3;
  localparam int BW = 64;

`ifdef ID_BYPASS_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk;
  logic              resetn;
  logic              in_valid;
  logic              in_allowin;
  logic [BW-1:0]     in_bus;
  logic [2*AW-1:0]   in_raddr;
  logic [1:0]        in_ruse;
  logic              flush;
  logic [2*AW-1:0]   rf_raddr;
  logic [2*DW-1:0]   rf_rdata;
  logic [NS-1:0]     fwd_valid;
  logic [NS-1:0]     fwd_ready;
  logic [NS*AW-1:0]  fwd_dest;
  logic [NS*DW-1:0]  fwd_data;
  logic              out_valid;
  logic              out_allowin;
  logic [BW-1:0]     out_bus;
  logic [2*DW-1:0]   out_src;
  logic [31:0]       stall_cnt;

  id_bypass_stage #(.DATA_W(DW), .REG_AW(AW), .NSRC(NS), .BUS_W(BW)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_allowin(in_allowin), .in_bus(in_bus),
    .in_raddr(in_raddr), .in_ruse(in_ruse), .flush(flush),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_allowin(out_allowin), .out_bus(out_bus),
    .out_src(out_src), .stall_cnt(stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [BW+2*DW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_stall = 32'd0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops one expected result for every downstream transfer.
  always @(negedge clk) begin
    logic [BW+2*DW-1:0] e;
    if (resetn && out_valid && out_allowin) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 128'(out_bus), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("out_bus", 128'(out_bus), 128'(e[BW+2*DW-1:2*DW]));
        chk("out_src", 128'(out_src), 128'(e[2*DW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [BW-1:0] b, input logic [DW-1:0] s1, input logic [DW-1:0] s0);
    exp_q.push_back({b, s1, s0});
  endtask

  task automatic set_fwd(input int i, input logic v, input logic r,
                         input logic [AW-1:0] d, input logic [DW-1:0] dat);
    fwd_valid[i]           = v;
    fwd_ready[i]           = r;
    fwd_dest[i*AW +: AW]   = d;
    fwd_data[i*DW +: DW]   = dat;
  endtask

  task automatic clr_fwd();
    fwd_valid = '0;
    fwd_ready = '0;
    fwd_dest  = '0;
    fwd_data  = '0;
  endtask

  // Presents one payload for exactly one edge (stage assumed able to accept).
  task automatic drive(input logic [BW-1:0] b, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a0, input logic [1:0] ru);
    in_bus   = b;
    in_raddr = {a1, a0};
    in_ruse  = ru;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] r1, r0;
    logic [AW-1:0] a1, a0;
    logic [1:0]    ru;
    logic [BW-1:0] b;
    bit            accepted;

    resetn = 1'b0; in_valid = 1'b0; in_bus = '0; in_raddr = '0; in_ruse = '0;
    flush = 1'b0; rf_raddr_dummy_init(); out_allowin = 1'b1;
    clr_fwd();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid",  128'(out_valid),  128'(1'b0));
    chk("rst_in_allowin", 128'(in_allowin), 128'(1'b1));
    chk("rst_stall_cnt",  128'(stall_cnt),  128'(0));
    chk("rst_out_bus",    128'(out_bus),    128'(0));
    chk("rst_out_src",    128'(out_src),    128'(0));
    chk("rst_rf_raddr",   128'(rf_raddr),   128'(0));
    tick();
    resetn = 1'b1;

    // Youngest producer wins over oldest on the same register.
    tick();
    set_fwd(0, 1'b1, 1'b1, 5'd5, 32'h11);
    set_fwd(2, 1'b1, 1'b1, 5'd5, 32'h33);
    rf_rdata = {32'hB1, 32'hB0};
    push(64'hA1, 32'hB1, FWD ? 32'h11 : 32'hB0);
    drive(64'hA1, 5'd9, 5'd5, 2'b11);
    @(negedge clk);
    chk("prio_out_valid",  128'(out_valid),  128'(FWD));
    chk("prio_in_allowin", 128'(in_allowin), 128'(FWD));
    chk("prio_rf_raddr",   128'(FWD ? 10'd0 : rf_raddr), 128'(FWD ? 10'd0 : {5'd9, 5'd5}));
    chk("prio_stall0",     128'(stall_cnt),  128'(0));
    tick();
    clr_fwd();
    if (!FWD) exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    chk("prio_out_valid2", 128'(out_valid), 128'(!FWD));
    chk("prio_stall1",     128'(stall_cnt), 128'(exp_stall));

    // Producer not ready for three cycles.
    tick();
    set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h77);
    rf_rdata = {32'hC1, 32'hC0};
    push(64'hA2, 32'h0, FWD ? 32'h77 : 32'hC0);
    drive(64'hA2, 5'd0, 5'd7, 2'b01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 128'(out_valid), 128'(1'b0));
      tick();
    end
    exp_stall = exp_stall + 32'd3;
    fwd_ready[0] = 1'b1;
    fwd_valid[0] = FWD;
    @(negedge clk);
    chk("stall_release", 128'(out_valid), 128'(1'b1));
    chk("stall_cnt3",    128'(stall_cnt), 128'(exp_stall));

    // Address 0 never stalls and reads as zero.
    tick();
    clr_fwd();
    set_fwd(1, 1'b1, 1'b0, 5'd0, 32'hDD);
    rf_rdata = {32'hE1, 32'hE0};
    push(64'hA3, 32'h0, 32'hE0);
    drive(64'hA3, 5'd0, 5'd3, 2'b11);
    @(negedge clk);
    chk("zero_out_valid", 128'(out_valid), 128'(1'b1));
    chk("zero_stall",     128'(stall_cnt), 128'(exp_stall));

    // Back-pressure holds the payload and is not a stall.
    tick();
    clr_fwd();
    out_allowin = 1'b0;
    rf_rdata = {32'hF1, 32'hF0};
    push(64'hA4, 32'hF1, 32'hF0);
    drive(64'hA4, 5'd2, 5'd1, 2'b11);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_out_valid",  128'(out_valid),  128'(1'b1));
      chk("bp_in_allowin", 128'(in_allowin), 128'(1'b0));
      chk("bp_out_bus",    128'(out_bus),    128'(64'hA4));
      chk("bp_stall",      128'(stall_cnt),  128'(exp_stall));
      tick();
    end
    out_allowin = 1'b1;
    tick();

    // Flush during a hazard stall, then flush overriding a capture.
    set_fwd(0, 1'b1, 1'b0, 5'd6, 32'h66);
    drive(64'hA5, 5'd0, 5'd6, 2'b01);
    @(negedge clk);
    chk("fl_held", 128'(out_valid), 128'(1'b0));
    tick();
    exp_stall = exp_stall + 32'd1;
    flush = 1'b1; in_valid = 1'b1; in_bus = 64'hA6; in_raddr = '0; in_ruse = 2'b00;
    tick();
    clr_fwd();
    in_bus = 64'hA7;
    @(negedge clk);
    chk("fl_out_valid",  128'(out_valid),  128'(1'b0));
    chk("fl_in_allowin", 128'(in_allowin), 128'(1'b1));
    chk("fl_stall_held", 128'(stall_cnt),  128'(exp_stall));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_override", 128'(out_valid), 128'(1'b0));

    // Asynchronous reset in the middle of a stall.
    tick();
    set_fwd(0, 1'b1, 1'b0, 5'd6, 32'h66);
    drive(64'hA8, 5'd0, 5'd6, 2'b01);
    tick();
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    chk("ar_pre_stall", 128'(stall_cnt), 128'(exp_stall));
    #2 resetn = 1'b0;
    #1;
    chk("ar_out_valid",  128'(out_valid),  128'(1'b0));
    chk("ar_stall_cnt",  128'(stall_cnt),  128'(0));
    chk("ar_in_allowin", 128'(in_allowin), 128'(1'b1));
    chk("ar_out_bus",    128'(out_bus),    128'(0));
    exp_stall = 32'd0;
    tick();
    tick();
    resetn = 1'b1;
    clr_fwd();
    @(negedge clk);
    chk("ar_no_stale", 128'(out_valid), 128'(1'b0));

    // Ready producer: bypassed when enabled, waited out when disabled.
    tick();
    set_fwd(1, 1'b1, 1'b1, 5'd4, 32'h44);
    rf_rdata = {32'h0, 32'h40};
    push(64'hA9, 32'h0, FWD ? 32'h44 : 32'h40);
    drive(64'hA9, 5'd0, 5'd4, 2'b01);
    @(negedge clk);
    chk("nb_out_valid", 128'(out_valid), 128'(FWD));
    tick();
    fwd_valid[1] = 1'b0;
    if (!FWD) exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    chk("nb_out_valid2", 128'(out_valid), 128'(!FWD));
    chk("nb_stall",      128'(stall_cnt), 128'(exp_stall));

    // Random burst without producers, random downstream back-pressure.
    tick();
    clr_fwd();
    r1 = $urandom; r0 = $urandom;
    rf_rdata = {r1, r0};
    for (int k = 0; k < 10; k++) begin
      b  = {$urandom, $urandom};
      a1 = 5'($urandom_range(0, 31));
      a0 = 5'($urandom_range(0, 31));
      ru = 2'($urandom_range(0, 3));
      push(b, (a1 == 5'd0) ? 32'h0 : r1, (a0 == 5'd0) ? 32'h0 : r0);
      in_bus = b; in_raddr = {a1, a0}; in_ruse = ru; in_valid = 1'b1;
      accepted = 1'b0;
      for (int w = 0; w < 20 && !accepted; w++) begin
        out_allowin = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (in_allowin) accepted = 1'b1;
        tick();
      end
      chk("burst_accept", 128'(accepted), 128'(1'b1));
    end
    in_valid = 1'b0;
    out_allowin = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("burst_stall",    128'(stall_cnt),     128'(exp_stall));
    chk("queue_drained",  128'(exp_q.size()),  128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // rf_rdata gets a defined start value before the first directed step.
  task automatic rf_raddr_dummy_init();
    rf_rdata = '0;
  endtask

endmodule
